dice_turn_controller: RTL and testbench
=======================================

// Module: dice_turn_controller
// PURPOSE
//  Frame-level consumer of the ROI color detector's result interface.
//  - Debounces per-frame results across consecutive frames.
//  - Turns a stable dice color into a move request for the board/piece mover.
//  - Uses a stable white background (dice removed) to close the turn and
//    advance to the next player.
//  - Sits between the color detector and the board renderer / game logic.
// PARAMETERS
//  STABLE_FRAMES  3       consecutive identical color frames needed to accept a roll (1..15)
//  WHITE_FRAMES   5       consecutive white frames needed to arm / end a turn (1..15)
//  MIN_CONF       16'd200 minimum color_confidence for a color frame to count
//  NUM_PLAYERS    2       number of players, 1..4; cur_player wraps modulo NUM_PLAYERS
//  TIMEOUT_FRAMES 16'd1800 frames allowed in ARMED before the turn is skipped (only with TURN_TIMEOUT_EN)
// PORTS
//  clk              in   1   system clock
//  reset            in   1   synchronous, active-high reset
//  frame_start      in   1   frame boundary pulse, the same pulse the detector receives
//  dominant_color   in   2   01=RED, 10=GREEN, 11=BLUE, 00=NONE
//  color_valid      in   1   detector color pulse
//  white_detected   in   1   detector white pulse
//  color_confidence in   16  pixel count of dominant_color
//  move_req         out  1   move request, held high until acknowledged
//  move_ack         in   1   mover acknowledge
//  move_steps       out  2   1..3 steps (RED=1, GREEN=2, BLUE=3); stable while move_req=1
//  move_player      out  2   player that owns the move; stable while move_req=1
//  cur_player       out  2   player whose turn it is
//  turn_done        out  1   1-cycle pulse when a turn ends
//  turn_skipped     out  1   1-cycle pulse on timeout skip; tied 0 without TURN_TIMEOUT_EN
//  state_dbg        out  3   encoded FSM state
// BEHAVIOUR
//  Reset:
//  - Synchronous reset gives: state=WAIT_CLEAR, all streak counters 0,
//    cur_player=0, move_req=0, move_steps=0, move_player=0, turn_done=0,
//    turn_skipped=0.
//  Frame sampling:
//  - frame_start is registered to fs_d. The detector result is valid in the cycle where fs_d=1.
//  - Each frame is classified once, at fs_d=1:
//    - COLOR(c): color_valid=1, color_confidence>=MIN_CONF, and c!=00.
//    - WHITE: white_detected=1 and color_valid=0. color_valid wins if both are 1.
//    - AMBIG: anything else.
//  - Pulses on color_valid / white_detected outside fs_d=1 are ignored.
//  Color streak:
//  - COLOR(c) with c equal to the last color: streak+1, saturating at 15.
//  - COLOR(c) with a different color: streak=1, last color=c.
//  - WHITE or AMBIG: streak=0.
//  White streak:
//  - WHITE: wstreak+1, saturating at 15.
//  - Anything else: wstreak=0.
//  - Both streak counters clear on every state transition.
//  FSM:
//  - WAIT_CLEAR -> ARMED when wstreak reaches WHITE_FRAMES.
//    Covers startup and a dice already present at reset.
//  - ARMED -> MOVE when streak reaches STABLE_FRAMES.
//    - Same cycle: move_steps = color code, move_player = cur_player.
//    - move_req=1 from the next cycle.
//  - MOVE: move_req held until move_ack=1 is sampled.
//    - Next cycle: move_req=0, state -> WAIT_REMOVE.
//    - Frames during MOVE are ignored; streaks stay 0.
//    - move_ack outside MOVE is ignored.
//  - WAIT_REMOVE -> ARMED when wstreak reaches WHITE_FRAMES.
//    - Same cycle: turn_done=1 and cur_player advances, wrapping to 0 after NUM_PLAYERS-1.
//    - Color frames here reset wstreak and never start a new roll.
//  Latency:
//  - Roll accept: move_req rises 1 cycle after the fs_d of the STABLE_FRAMES-th matching frame.
//  Reset mid-operation:
//  - A pending request is dropped; move_req falls in the reset cycle.
//  NUM_PLAYERS=1:
//  - cur_player stays 0.
// CONFIGURATION
//  TURN_TIMEOUT_EN defined:
//  - A 16-bit frame counter runs in ARMED, incrementing at each fs_d and clearing on entry to ARMED.
//  - When it reaches TIMEOUT_FRAMES with no accepted roll:
//    - turn_skipped is a 1-cycle pulse.
//    - cur_player advances.
//    - State stays ARMED and the counter and streaks clear.
//  - Accepting a roll in the same cycle takes priority over the timeout.
//  TURN_TIMEOUT_EN undefined:
//  - No counter is built, turn_skipped is constant 0, ARMED waits indefinitely.
// TESTING
//  T1 reset, 5 WHITE frames -> state ARMED after 5th fs_d; 4 WHITE frames only -> still WAIT_CLEAR
//  T2 ARMED, 3 frames GREEN conf=500 -> move_req=1, move_steps=2, move_player=0; ack after 7 cycles -> move_req=0 next cycle
//  T3 ARMED, RED,RED,BLUE,BLUE,BLUE (conf 300) -> one request with steps=3; RED,AMBIG,RED,RED -> no request
//  T4 ARMED, 3 RED frames conf=150 (<MIN_CONF) -> no request; simultaneous color_valid+white_detected counts as COLOR
//  T5 WAIT_REMOVE, 5 WHITE frames -> turn_done pulse, cur_player 0->1; repeat with NUM_PLAYERS=2 -> wraps to 0
//  T6 TURN_TIMEOUT_EN, TIMEOUT_FRAMES=10, 10 AMBIG frames in ARMED -> turn_skipped pulse, cur_player+1; reset asserted during MOVE -> all outputs at reset values

Source files
------------

// File: rtl/dice_turn_controller_if.sv
// Detector-result and move-handshake bundle for dice_turn_controller.
// The master side drives frames and acknowledges moves; the controller is the slave.
interface dice_turn_controller_if;
    logic        frame_start;
    logic [1:0]  dominant_color;
    logic        color_valid;
    logic        white_detected;
    logic [15:0] color_confidence;
    logic        move_req;
    logic        move_ack;
    logic [1:0]  move_steps;
    logic [1:0]  move_player;

    modport master (
        output frame_start, dominant_color, color_valid, white_detected,
               color_confidence, move_ack,
        input  move_req, move_steps, move_player
    );

    modport slave (
        input  frame_start, dominant_color, color_valid, white_detected,
               color_confidence, move_ack,
        output move_req, move_steps, move_player
    );
endinterface

// File: rtl/dice_turn_controller.sv
// Debounces per-frame dice colour results into move requests and closes turns on a stable white background.
// Optional TURN_TIMEOUT_EN macro adds a frame-count timeout that skips an idle player.
module dice_turn_controller #(
    parameter int unsigned STABLE_FRAMES  = 3,
    parameter int unsigned WHITE_FRAMES   = 5,
    parameter logic [15:0] MIN_CONF       = 16'd200,
    parameter int unsigned NUM_PLAYERS    = 2
`ifdef TURN_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT_FRAMES = 16'd1800
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    dice_turn_controller_if.slave        bus,
    output logic [1:0]                   cur_player,
    output logic                         turn_done,
    output logic                         turn_skipped,
    output logic [2:0]                   state_dbg
);

    typedef enum logic [2:0] {
        WAIT_CLEAR  = 3'd0,
        ARMED       = 3'd1,
        MOVE        = 3'd2,
        WAIT_REMOVE = 3'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        fs_d_reg;
    logic [3:0]  streak_reg, streak_next;
    logic [3:0]  wstreak_reg, wstreak_next;
    logic [1:0]  last_color_reg, last_color_next;
    logic [1:0]  cur_player_reg, cur_player_next;
    logic        move_req_reg, move_req_next;
    logic [1:0]  move_steps_reg, move_steps_next;
    logic [1:0]  move_player_reg, move_player_next;
    logic        turn_done_reg, turn_done_next;
    logic        is_color, is_white;
    logic [1:0]  player_adv;

    // Classification is only meaningful in the fs_d cycle; colour wins over white.
    assign is_color = bus.color_valid && (bus.color_confidence >= MIN_CONF)
                      && (bus.dominant_color != 2'b00);
    assign is_white = bus.white_detected && !bus.color_valid;

    assign player_adv = (cur_player_reg >= 2'(NUM_PLAYERS - 1)) ? 2'd0
                                                                : cur_player_reg + 2'd1;

`ifdef TURN_TIMEOUT_EN
    logic [15:0] frame_cnt_reg, frame_cnt_next;
    logic        turn_skipped_reg, turn_skipped_next;
`endif

    always_comb begin
        state_next       = state_reg;
        streak_next      = streak_reg;
        wstreak_next     = wstreak_reg;
        last_color_next  = last_color_reg;
        cur_player_next  = cur_player_reg;
        move_req_next    = move_req_reg;
        move_steps_next  = move_steps_reg;
        move_player_next = move_player_reg;
        turn_done_next   = 1'b0;
`ifdef TURN_TIMEOUT_EN
        turn_skipped_next = 1'b0;
        frame_cnt_next    = frame_cnt_reg;
        if (state_reg == ARMED && fs_d_reg)
            frame_cnt_next = frame_cnt_reg + 16'd1;
`endif

        // Streak bookkeeping; frames arriving while a move is pending are dropped.
        if (fs_d_reg && state_reg != MOVE) begin
            if (is_color) begin
                if (bus.dominant_color == last_color_reg) begin
                    streak_next = (streak_reg == 4'd15) ? 4'd15 : streak_reg + 4'd1;
                end else begin
                    streak_next     = 4'd1;
                    last_color_next = bus.dominant_color;
                end
                wstreak_next = 4'd0;
            end else begin
                streak_next  = 4'd0;
                wstreak_next = !is_white ? 4'd0
                             : (wstreak_reg == 4'd15) ? 4'd15 : wstreak_reg + 4'd1;
            end
        end

        case (state_reg)
            WAIT_CLEAR: begin
                if (fs_d_reg && wstreak_next >= 4'(WHITE_FRAMES))
                    state_next = ARMED;
            end
            ARMED: begin
                if (fs_d_reg && is_color && streak_next >= 4'(STABLE_FRAMES)) begin
                    state_next       = MOVE;
                    move_req_next    = 1'b1;
                    move_steps_next  = bus.dominant_color;
                    move_player_next = cur_player_reg;
                end
`ifdef TURN_TIMEOUT_EN
                else if (frame_cnt_next >= TIMEOUT_FRAMES) begin
                    turn_skipped_next = 1'b1;
                    cur_player_next   = player_adv;
                    frame_cnt_next    = 16'd0;
                    streak_next       = 4'd0;
                    wstreak_next      = 4'd0;
                end
`endif
            end
            MOVE: begin
                if (bus.move_ack) begin
                    move_req_next = 1'b0;
                    state_next    = WAIT_REMOVE;
                end
            end
            WAIT_REMOVE: begin
                if (fs_d_reg && wstreak_next >= 4'(WHITE_FRAMES)) begin
                    state_next      = ARMED;
                    turn_done_next  = 1'b1;
                    cur_player_next = player_adv;
                end
            end
            default: state_next = WAIT_CLEAR;
        endcase

        if (state_next != state_reg) begin
            streak_next  = 4'd0;
            wstreak_next = 4'd0;
        end
`ifdef TURN_TIMEOUT_EN
        // Counter only lives inside ARMED and restarts on every entry.
        if (state_reg != ARMED || state_next != ARMED)
            frame_cnt_next = 16'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= WAIT_CLEAR;
            fs_d_reg        <= 1'b0;
            streak_reg      <= 4'd0;
            wstreak_reg     <= 4'd0;
            last_color_reg  <= 2'b00;
            cur_player_reg  <= 2'd0;
            move_req_reg    <= 1'b0;
            move_steps_reg  <= 2'd0;
            move_player_reg <= 2'd0;
            turn_done_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            fs_d_reg        <= bus.frame_start;
            streak_reg      <= streak_next;
            wstreak_reg     <= wstreak_next;
            last_color_reg  <= last_color_next;
            cur_player_reg  <= cur_player_next;
            move_req_reg    <= move_req_next;
            move_steps_reg  <= move_steps_next;
            move_player_reg <= move_player_next;
            turn_done_reg   <= turn_done_next;
        end
    end

`ifdef TURN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_reg    <= 16'd0;
            turn_skipped_reg <= 1'b0;
        end else begin
            frame_cnt_reg    <= frame_cnt_next;
            turn_skipped_reg <= turn_skipped_next;
        end
    end
    assign turn_skipped = turn_skipped_reg;
`else
    assign turn_skipped = 1'b0;
`endif

    assign bus.move_req    = move_req_reg;
    assign bus.move_steps  = move_steps_reg;
    assign bus.move_player = move_player_reg;
    assign cur_player      = cur_player_reg;
    assign turn_done       = turn_done_reg;
    assign state_dbg       = state_reg;

endmodule

// File: tb/tb_dice_turn_controller.sv
// Scoreboard bench for dice_turn_controller: expected moves are queued as frames are driven
// and checked when move_req rises; turn/skip pulses and FSM state are checked inline.
module tb_dice_turn_controller;

    localparam logic [2:0] ST_WC = 3'd0;
    localparam logic [2:0] ST_AR = 3'd1;
    localparam logic [2:0] ST_WR = 3'd3;

    typedef struct packed {
        logic [1:0] player;
        logic [1:0] steps;
    } mv_t;

    logic       clk;
    logic       reset;
    logic [1:0] cur_player;
    logic       turn_done;
    logic       turn_skipped;
    logic [2:0] state_dbg;

    dice_turn_controller_if bus ();

    dice_turn_controller #(
        .STABLE_FRAMES (3),
        .WHITE_FRAMES  (5),
        .MIN_CONF      (16'd200),
        .NUM_PLAYERS   (2)
`ifdef TURN_TIMEOUT_EN
        ,
        .TIMEOUT_FRAMES(16'd10)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .cur_player   (cur_player),
        .turn_done    (turn_done),
        .turn_skipped (turn_skipped),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    int  done_cnt = 0;
    int  skip_cnt = 0;
    logic req_prev = 1'b0;
    mv_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: compare each new request against the oldest expectation.
    always @(negedge clk) begin
        mv_t e;
        if (bus.move_req && !req_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_req", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("move_steps", 32'(bus.move_steps), 32'(e.steps));
                check("move_player", 32'(bus.move_player), 32'(e.player));
                $display("move req: steps=%0d player=%0d", bus.move_steps, bus.move_player);
            end
        end
        if (turn_done)    done_cnt++;
        if (turn_skipped) skip_cnt++;
        req_prev = bus.move_req;
    end

    task automatic frame(input logic cv, input logic wd, input logic [1:0] col,
                         input logic [15:0] conf);
        @(negedge clk) bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start      = 1'b0;
        bus.color_valid      = cv;
        bus.white_detected   = wd;
        bus.dominant_color   = col;
        bus.color_confidence = conf;
        @(negedge clk);
        bus.color_valid      = 1'b0;
        bus.white_detected   = 1'b0;
        bus.dominant_color   = 2'b00;
        bus.color_confidence = 16'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic white();
        frame(1'b0, 1'b1, 2'b00, 16'd0);
    endtask

    task automatic ambig();
        frame(1'b0, 1'b0, 2'b00, 16'd0);
    endtask

    task automatic color(input logic [1:0] c, input logic [15:0] conf);
        frame(1'b1, 1'b0, c, conf);
    endtask

    // Detector pulse with no frame boundary around it.
    task automatic stray(input logic [1:0] c);
        @(negedge clk);
        bus.color_valid      = 1'b1;
        bus.dominant_color   = c;
        bus.color_confidence = 16'd500;
        @(negedge clk);
        bus.color_valid      = 1'b0;
        bus.dominant_color   = 2'b00;
        bus.color_confidence = 16'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_ack(input int delay);
        int n = 0;
        while (!bus.move_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(bus.move_req), 32'd1);
        repeat (delay) @(negedge clk);
        check("req_held", 32'(bus.move_req), 32'd1);
        bus.move_ack = 1'b1;
        @(negedge clk);
        bus.move_ack = 1'b0;
        check("req_drop", 32'(bus.move_req), 32'd0);
        check("state_after_ack", 32'(state_dbg), 32'(ST_WR));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},  32'(state_dbg),       32'(ST_WC));
        check({tag, "_req"},    32'(bus.move_req),    32'd0);
        check({tag, "_steps"},  32'(bus.move_steps),  32'd0);
        check({tag, "_mplay"},  32'(bus.move_player), 32'd0);
        check({tag, "_player"}, 32'(cur_player),      32'd0);
        check({tag, "_done"},   32'(turn_done),       32'd0);
        check({tag, "_skip"},   32'(turn_skipped),    32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pl;
        bus.frame_start      = 1'b0;
        bus.dominant_color   = 2'b00;
        bus.color_valid      = 1'b0;
        bus.white_detected   = 1'b0;
        bus.color_confidence = 16'd0;
        bus.move_ack         = 1'b0;
        reset                = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Arming needs five consecutive white frames.
        repeat (4) white();
        ambig();
        repeat (4) white();
        check("wc_after4", 32'(state_dbg), 32'(ST_WC));
        white();
        check("armed_after5", 32'(state_dbg), 32'(ST_AR));
        $display("armed: state=%0d", state_dbg);

        repeat (3) stray(2'b10);
        check("stray_ignored", 32'(state_dbg), 32'(ST_AR));

        // Three GREEN frames roll 2 for player 0.
        color(2'b10, 16'd500);
        color(2'b10, 16'd500);
        check("no_req_2frames", 32'(bus.move_req), 32'd0);
        exp_q.push_back('{player: 2'd0, steps: 2'd2});
        color(2'b10, 16'd500);
        do_ack(7);

        // Colour frames while waiting for removal do nothing.
        repeat (3) white();
        repeat (3) color(2'b01, 16'd300);
        check("wr_color_no_roll", 32'(state_dbg), 32'(ST_WR));
        repeat (4) white();
        check("wr_after4", 32'(state_dbg), 32'(ST_WR));
        check("done_cnt0", 32'(done_cnt), 32'd0);
        white();
        check("turn1_state", 32'(state_dbg), 32'(ST_AR));
        check("turn1_done", 32'(done_cnt), 32'd1);
        check("turn1_player", 32'(cur_player), 32'd1);
        $display("turn done: cur_player=%0d", cur_player);

        // Colour change restarts the streak.
        exp_q.push_back('{player: 2'd1, steps: 2'd3});
        color(2'b01, 16'd300);
        color(2'b01, 16'd300);
        color(2'b11, 16'd300);
        color(2'b11, 16'd300);
        color(2'b11, 16'd300);
        do_ack(2);
        repeat (5) white();
        check("turn2_done", 32'(done_cnt), 32'd2);
        check("turn2_wrap", 32'(cur_player), 32'd0);

        color(2'b01, 16'd300);
        ambig();
        color(2'b01, 16'd300);
        color(2'b01, 16'd300);
        check("ambig_break", 32'(state_dbg), 32'(ST_AR));

        repeat (3) color(2'b01, 16'd150);
        check("low_conf", 32'(state_dbg), 32'(ST_AR));

        // Colour+white together is colour; conf exactly at threshold counts.
        exp_q.push_back('{player: 2'd0, steps: 2'd2});
        repeat (3) frame(1'b1, 1'b1, 2'b10, 16'd200);
        do_ack(0);
        check("roll_over_timeout", 32'(skip_cnt), 32'd0);
        repeat (5) white();
        check("turn3_player", 32'(cur_player), 32'd1);

        repeat (9) ambig();
        check("skip_before", 32'(skip_cnt), 32'd0);
        ambig();
`ifdef TURN_TIMEOUT_EN
        check("skip_pulse", 32'(skip_cnt), 32'd1);
        check("skip_player", 32'(cur_player), 32'd0);
        exp_pl = 0;
`else
        check("no_skip", 32'(skip_cnt), 32'd0);
        check("no_skip_player", 32'(cur_player), 32'd1);
        exp_pl = 1;
`endif
        check("skip_state", 32'(state_dbg), 32'(ST_AR));

        // Reset while a request is pending drops it.
        exp_q.push_back('{player: 2'(exp_pl), steps: 2'd1});
        repeat (3) color(2'b01, 16'd300);
        check("pre_reset_req", 32'(bus.move_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        @(negedge clk);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
